// File: rtl/hbm_arb_pkg.sv
// ---------------------------------------------------------------------------
// hbm_arb_pkg
//   Shared types for the 2:1 HBM AXI write-channel arbiter.
//   - Default interface widths as used by the HBM channel initiator.
//   - Packed payload structs for the AW, W and B channels, at those widths.
//   - SRC_W: width of the source-master prefix added to downstream IDs.
//   - aw_state_e: states of the AW grant FSM.
// ---------------------------------------------------------------------------
package hbm_arb_pkg;

  localparam int SRC_W      = 1;
  localparam int HBM_ADDR_W = 64;
  localparam int HBM_DATA_W = 256;
  localparam int HBM_ID_W   = 7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } aw_state_e;

  typedef struct packed {
    logic [HBM_ID_W-1:0]   id;
    logic [HBM_ADDR_W-1:0] addr;
    logic [7:0]            len;
  } aw_pld_t;

  typedef struct packed {
    logic [HBM_DATA_W-1:0]   data;
    logic [HBM_DATA_W/8-1:0] strb;
    logic                    last;
  } w_pld_t;

  typedef struct packed {
    logic [HBM_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_pld_t;

endpackage

// File: rtl/hbm_arb_owner_fifo.sv
// ---------------------------------------------------------------------------
// hbm_arb_owner_fifo
//   1-bit wide FIFO recording which master owns each granted-but-unfinished
//   write burst. The head tells the W mux whose beats to pass next.
//
//   Ports:
//     clk100_in_clk       clock
//     axi_reset_in_reset  synchronous active-high reset, empties the FIFO
//     push / push_data    enqueue the granted master index
//     pop                 dequeue on acceptance of a burst's last beat
//     full / empty        occupancy flags
//     head                owner of the oldest outstanding burst
//
//   Pointers carry one extra wrap bit so full and empty are distinguished by
//   comparing the MSBs while the lower bits match.
// ---------------------------------------------------------------------------
module hbm_arb_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk100_in_clk,
  input  logic axi_reset_in_reset,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic [DEPTH-1:0] mem_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk100_in_clk) begin
    if (axi_reset_in_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/hbm_axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// hbm_axi_wr_arbiter
//   2:1 AXI4 write-channel arbiter (AW/W/B) sharing one HBM NoC initiator
//   port between two masters. Read channels do not pass through here.
//
//   AW: round-robin grant, one registered downstream AW in flight at a time.
//   W : combinational mux steered by the owner FIFO head, so bursts follow
//       AW grant order and never interleave.
//   B : combinational demux on the source prefix bit of the downstream ID.
//
//   Ports (per-master buses pack master 0 in the low slice):
//     clk100_in_clk, axi_reset_in_reset   clock, sync active-high reset
//     s_aw_valid/ready/pld                upstream AW, pld = {id, addr, len}
//     s_w_valid/ready/pld                 upstream W,  pld = {data, strb, last}
//     s_b_valid/ready/pld                 upstream B,  pld = {id, resp}
//     m_aw_valid/ready/pld                downstream AW, pld = {src, id, addr, len}
//     m_w_valid/ready/pld                 downstream W,  pld = {data, strb, last}
//     m_b_valid/ready/pld                 downstream B,  pld = {src, id, resp}
//
//   Build option:
//     HBM_ARB_FIXED_PRIO_EN  master 0 always wins an AW grant when it
//                            requests; rr_last is not kept.
//
//   AW FSM:
//     state | meaning
//     IDLE  | no downstream AW pending; may grant one upstream AW
//     HOLD  | latched AW presented on m_aw, waiting for m_aw_ready
// ---------------------------------------------------------------------------
module hbm_axi_wr_arbiter
  import hbm_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 7,
  parameter int OWN_DEPTH = 4
) (
  input  logic                             clk100_in_clk,
  input  logic                             axi_reset_in_reset,

  input  logic [1:0]                       s_aw_valid,
  output logic [1:0]                       s_aw_ready,
  input  logic [2*(ID_W+ADDR_W+8)-1:0]     s_aw_pld,

  input  logic [1:0]                       s_w_valid,
  output logic [1:0]                       s_w_ready,
  input  logic [2*(DATA_W+DATA_W/8+1)-1:0] s_w_pld,

  output logic [1:0]                       s_b_valid,
  input  logic [1:0]                       s_b_ready,
  output logic [2*(ID_W+2)-1:0]            s_b_pld,

  output logic                             m_aw_valid,
  input  logic                             m_aw_ready,
  output logic [ID_W+1+ADDR_W+8-1:0]       m_aw_pld,

  output logic                             m_w_valid,
  input  logic                             m_w_ready,
  output logic [DATA_W+DATA_W/8+1-1:0]     m_w_pld,

  input  logic                             m_b_valid,
  output logic                             m_b_ready,
  input  logic [ID_W+3-1:0]                m_b_pld
);

  localparam int AW_PW  = ID_W + ADDR_W + 8;
  localparam int MAW_PW = SRC_W + AW_PW;
  localparam int W_PW   = DATA_W + DATA_W/8 + 1;
  localparam int SB_PW  = ID_W + 2;
  localparam int MB_PW  = SRC_W + SB_PW;

  aw_state_e         state_q;
  aw_state_e         state_d;
  logic [MAW_PW-1:0] aw_pld_q;
  logic [AW_PW-1:0]  sel_aw_pld;
  logic              grant_en;
  logic              grant_idx;

  logic              own_push;
  logic              own_pop;
  logic              own_full;
  logic              own_empty;
  logic              own_head;

  logic              b_src;

  // ---------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------
`ifdef HBM_ARB_FIXED_PRIO_EN
  // Master 1 only wins when master 0 is not requesting.
  assign grant_idx = ~s_aw_valid[0];
`else
  logic rr_last_q;

  // Alternate on contention; a lone requester always wins.
  always_comb begin
    if (&s_aw_valid) begin
      grant_idx = ~rr_last_q;
    end else begin
      grant_idx = s_aw_valid[1];
    end
  end

  // Reset to 1 so master 0 wins the first contended grant.
  always_ff @(posedge clk100_in_clk) begin
    if (axi_reset_in_reset) begin
      rr_last_q <= 1'b1;
    end else if (grant_en) begin
      rr_last_q <= grant_idx;
    end
  end
`endif

  assign sel_aw_pld = grant_idx ? s_aw_pld[2*AW_PW-1 -: AW_PW]
                                : s_aw_pld[AW_PW-1:0];

  // ---------------------------------------------------------------------
  // AW FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    s_aw_ready = '0;
    grant_en   = 1'b0;
    own_push   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ready is gated by reset so no grant leaks out while the block is
        // being cleared.
        if (!axi_reset_in_reset && (|s_aw_valid) && !own_full) begin
          grant_en              = 1'b1;
          s_aw_ready[grant_idx] = 1'b1;
          own_push              = 1'b1;
          state_d               = HOLD;
        end
      end
      HOLD: begin
        if (m_aw_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100_in_clk) begin
    if (axi_reset_in_reset) begin
      state_q  <= IDLE;
      aw_pld_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        aw_pld_q <= {grant_idx, sel_aw_pld};
      end
    end
  end

  assign m_aw_valid = (state_q == HOLD) && !axi_reset_in_reset;
  assign m_aw_pld   = aw_pld_q;

  // ---------------------------------------------------------------------
  // Owner FIFO: one entry per granted burst whose last beat is still due
  // ---------------------------------------------------------------------
  hbm_arb_owner_fifo #(
    .DEPTH (OWN_DEPTH)
  ) u_owner_fifo (
    .clk100_in_clk      (clk100_in_clk),
    .axi_reset_in_reset (axi_reset_in_reset),
    .push               (own_push),
    .push_data          (grant_idx),
    .pop                (own_pop),
    .full               (own_full),
    .empty              (own_empty),
    .head               (own_head)
  );

  // ---------------------------------------------------------------------
  // W mux: only the head owner's beats reach the initiator
  // ---------------------------------------------------------------------
  always_comb begin
    m_w_valid = 1'b0;
    m_w_pld   = '0;
    s_w_ready = '0;
    if (!own_empty && !axi_reset_in_reset) begin
      m_w_valid           = s_w_valid[own_head];
      m_w_pld             = own_head ? s_w_pld[2*W_PW-1 -: W_PW]
                                     : s_w_pld[W_PW-1:0];
      s_w_ready[own_head] = m_w_ready;
    end
  end

  // last is the LSB of the W payload.
  assign own_pop = m_w_valid & m_w_ready & m_w_pld[0];

  // ---------------------------------------------------------------------
  // B demux: route by src prefix, strip it on the way up
  // ---------------------------------------------------------------------
  assign b_src = m_b_pld[MB_PW-1];

  always_comb begin
    s_b_valid = '0;
    s_b_pld   = '0;
    m_b_ready = 1'b0;
    if (!axi_reset_in_reset) begin
      s_b_valid[b_src] = m_b_valid;
      m_b_ready        = s_b_ready[b_src];
      if (b_src) begin
        s_b_pld[2*SB_PW-1 -: SB_PW] = m_b_pld[SB_PW-1:0];
      end else begin
        s_b_pld[SB_PW-1:0] = m_b_pld[SB_PW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hbm_axi_wr_arbiter.sv
`timescale 1ns/1ps
module tb_hbm_axi_wr_arbiter;
  import hbm_arb_pkg::*;

  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 256;
  localparam int ID_W      = 7;
  localparam int OWN_DEPTH = 4;
  localparam int AWP  = ID_W + ADDR_W + 8;
  localparam int MAWP = AWP + 1;
  localparam int WP   = DATA_W + DATA_W/8 + 1;
  localparam int SBP  = ID_W + 2;
  localparam int MBP  = SBP + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        s_aw_valid = '0;
  logic [1:0]        s_aw_ready;
  logic [2*AWP-1:0]  s_aw_pld = '0;
  logic [1:0]        s_w_valid = '0;
  logic [1:0]        s_w_ready;
  logic [2*WP-1:0]   s_w_pld = '0;
  logic [1:0]        s_b_valid;
  logic [1:0]        s_b_ready = '0;
  logic [2*SBP-1:0]  s_b_pld;
  logic              m_aw_valid;
  logic              m_aw_ready = 1'b0;
  logic [MAWP-1:0]   m_aw_pld;
  logic              m_w_valid;
  logic              m_w_ready = 1'b0;
  logic [WP-1:0]     m_w_pld;
  logic              m_b_valid = 1'b0;
  logic              m_b_ready;
  logic [MBP-1:0]    m_b_pld = '0;

  hbm_axi_wr_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .OWN_DEPTH(OWN_DEPTH)
  ) dut (
    .clk100_in_clk(clk), .axi_reset_in_reset(rst),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_pld(s_aw_pld),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_pld(s_w_pld),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_pld(s_b_pld),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_pld(m_aw_pld),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_pld(m_w_pld),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_pld(m_b_pld)
  );

  int checks = 0;
  int failures = 0;

  // stimulus queues (what each master still has to send)
  logic [AWP-1:0]  aw_gen [2][$];
  logic [WP-1:0]   w_gen  [2][$];
  // scoreboard queues (what must come out, in order)
  logic [MAWP-1:0] exp_aw [2][$];
  logic [WP-1:0]   exp_w  [2][$];
  logic [SBP-1:0]  exp_b  [2][$];
  logic [ID_W:0]   b_pending[$];   // {src,id} of AWs accepted downstream
  int              own_q[$];       // model: owners of unfinished bursts
  int              grant_log[$];   // masters actually granted, in order
  bit              model_hold = 1'b0;
  bit              last_g = 1'b1;
  int              mw_beats0 = 0;

  bit [1:0] aw_en = '1;
  bit [1:0] w_en = '1;
  int       aw_gap = 0;
  int       w_gap = 0;
  int       rdy_p = 100;

  logic [1:0] aw_hs = '0;
  logic [1:0] w_hs = '0;
  bit         mb_hs = 1'b0;
  bit         mb_v = 1'b0;
  bit              prev_aw_stall = 1'b0;
  logic [MAWP-1:0] prev_aw_pld = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------
  // Monitor / scoreboard, sampled mid-cycle
  // -------------------------------------------------------------------
  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    logic [WP-1:0] e;
    int qn, o, s;
    if (rst) begin
      aw_hs = '0; w_hs = '0; mb_hs = 1'b0; prev_aw_stall = 1'b0;
    end else begin
      aw_hs = s_aw_valid & s_aw_ready;
      w_hs  = s_w_valid & s_w_ready;
      mb_hs = m_b_valid & m_b_ready;
      qn = own_q.size();

      // downstream AW: present exactly while one is outstanding
      chk("m_aw_valid", m_aw_valid, model_hold);
      if (prev_aw_stall) chk("m_aw_pld_stable", m_aw_pld, prev_aw_pld);
      prev_aw_stall = m_aw_valid && !m_aw_ready;
      prev_aw_pld   = m_aw_pld;

      // grant rule: one at a time, at most OWN_DEPTH unfinished bursts
      exp_rdy = '0;
      if (!model_hold && qn < OWN_DEPTH && s_aw_valid != 2'b00) begin
        if (s_aw_valid == 2'b11) begin
`ifdef HBM_ARB_FIXED_PRIO_EN
          exp_rdy = 2'b01;
`else
          exp_rdy = last_g ? 2'b01 : 2'b10;
`endif
        end else begin
          exp_rdy = s_aw_valid;
        end
      end
      chk("s_aw_ready", s_aw_ready, exp_rdy);

      // W routing follows the oldest unfinished burst
      if (qn > 0) begin
        o = own_q[0];
        chk("m_w_valid", m_w_valid, s_w_valid[o]);
        chk("s_w_ready", s_w_ready, m_w_ready ? ((o == 1) ? 2'b10 : 2'b01) : 2'b00);
      end else begin
        chk("m_w_valid_idle", m_w_valid, 1'b0);
        chk("s_w_ready_idle", s_w_ready, 2'b00);
      end
      if (m_w_valid && m_w_ready) begin
        chk("w_has_owner", qn > 0, 1'b1);
        if (qn > 0) begin
          o = own_q[0];
          chk("w_beat_expected", exp_w[o].size() > 0, 1'b1);
          if (exp_w[o].size() > 0) begin
            e = exp_w[o].pop_front();
            chk("m_w_pld", m_w_pld, e);
            if (e[0]) own_q.delete(0);
          end
          if (o == 0) mw_beats0++;
        end
      end

      // downstream AW acceptance
      if (m_aw_valid && m_aw_ready) begin
        s = int'(m_aw_pld[MAWP-1]);
        chk("m_aw_expected", exp_aw[s].size() > 0, 1'b1);
        if (exp_aw[s].size() > 0) chk("m_aw_pld", m_aw_pld, exp_aw[s].pop_front());
        b_pending.push_back(m_aw_pld[MAWP-1 -: ID_W+1]);
        model_hold = 1'b0;
      end

      // model grant
      if (exp_rdy != 2'b00) begin
        o = exp_rdy[1] ? 1 : 0;
        own_q.push_back(o);
        last_g = o[0];
        model_hold = 1'b1;
      end
      if (aw_hs != 2'b00) grant_log.push_back(aw_hs[1] ? 1 : 0);

      // B routing
      if (m_b_valid) begin
        s = int'(m_b_pld[MBP-1]);
        chk("s_b_valid", s_b_valid, (s == 1) ? 2'b10 : 2'b01);
        chk("m_b_ready", m_b_ready, s_b_ready[s]);
      end else begin
        chk("s_b_valid_idle", s_b_valid, 2'b00);
      end
      for (int i = 0; i < 2; i++) begin
        if (s_b_valid[i] && s_b_ready[i]) begin
          chk("b_expected", exp_b[i].size() > 0, 1'b1);
          if (exp_b[i].size() > 0) chk("s_b_pld", s_b_pld[i*SBP +: SBP], exp_b[i].pop_front());
        end
      end
    end
  end

  // -------------------------------------------------------------------
  // Drivers: both masters plus the downstream initiator
  // -------------------------------------------------------------------
  always @(posedge clk) begin
    logic [1:0] r;
    logic [ID_W:0] bp;
    #1;
    if (rst) begin
      s_aw_valid = '0; s_w_valid = '0; s_aw_pld = '0; s_w_pld = '0;
      mb_v = 1'b0; m_b_valid = 1'b0; m_b_pld = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (aw_hs[i] && aw_gen[i].size() > 0) aw_gen[i].delete(0);
        if (w_hs[i] && w_gen[i].size() > 0) w_gen[i].delete(0);
      end
      if (mb_hs) mb_v = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!(s_aw_valid[i] && !aw_hs[i]))
          s_aw_valid[i] = aw_en[i] && aw_gen[i].size() > 0 && ($urandom_range(99) >= aw_gap);
        s_aw_pld[i*AWP +: AWP] = (aw_gen[i].size() > 0) ? aw_gen[i][0] : '0;
        if (!(s_w_valid[i] && !w_hs[i]))
          s_w_valid[i] = w_en[i] && w_gen[i].size() > 0 && ($urandom_range(99) >= w_gap);
        s_w_pld[i*WP +: WP] = (w_gen[i].size() > 0) ? w_gen[i][0] : '0;
        s_b_ready[i] = ($urandom_range(99) < rdy_p);
      end
      m_aw_ready = ($urandom_range(99) < rdy_p);
      m_w_ready  = ($urandom_range(99) < rdy_p);
      if (!mb_v && b_pending.size() > 0 && ($urandom_range(99) < rdy_p)) begin
        bp = b_pending[0];
        b_pending.delete(0);
        r = 2'($urandom_range(3));
        m_b_pld = {bp, r};
        exp_b[int'(bp[ID_W])].push_back({bp[ID_W-1:0], r});
        mb_v = 1'b1;
      end
      m_b_valid = mb_v;
    end
  end

  // -------------------------------------------------------------------
  // Phase helpers
  // -------------------------------------------------------------------
  task automatic gen_write(input int m, input logic [ADDR_W-1:0] addr, input int len, input bit fixed);
    aw_pld_t a;
    w_pld_t  w;
    logic [MAWP-1:0] ea;
    a.id   = 7'($urandom);
    a.addr = addr;
    a.len  = 8'(len);
    ea = {m[0], a};
    aw_gen[m].push_back(a);
    exp_aw[m].push_back(ea);
    for (int b = 0; b <= len; b++) begin
      for (int k = 0; k < DATA_W/32; k++) w.data[k*32 +: 32] = fixed ? 32'h0101_0101 : $urandom;
      w.strb = fixed ? '1 : $urandom;
      w.last = (b == len);
      w_gen[m].push_back(w);
      exp_w[m].push_back(w);
    end
  endtask

  function automatic bit tb_idle();
    bit q = 1'b1;
    for (int i = 0; i < 2; i++)
      if (aw_gen[i].size() || w_gen[i].size() || exp_aw[i].size() || exp_w[i].size() || exp_b[i].size()) q = 1'b0;
    return q && own_q.size() == 0 && b_pending.size() == 0 && !mb_v && !model_hold;
  endfunction

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (!tb_idle() && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(nm, tb_idle(), 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_s_aw_ready", s_aw_ready, 2'b00);
    chk("rst_m_aw_valid", m_aw_valid, 1'b0);
    chk("rst_m_aw_pld",   m_aw_pld, '0);
    chk("rst_m_w_valid",  m_w_valid, 1'b0);
    chk("rst_m_w_pld",    m_w_pld, '0);
    chk("rst_s_w_ready",  s_w_ready, 2'b00);
    chk("rst_s_b_valid",  s_b_valid, 2'b00);
    chk("rst_s_b_pld",    s_b_pld, '0);
    chk("rst_m_b_ready",  m_b_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      aw_gen[i].delete(); w_gen[i].delete();
      exp_aw[i].delete(); exp_w[i].delete(); exp_b[i].delete();
    end
    b_pending.delete(); own_q.delete(); grant_log.delete();
    model_hold = 1'b0; last_g = 1'b1; mw_beats0 = 0;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  // -------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------
  initial begin
    int n;
    int idx;

    // single write from master 0
    do_reset();
    gen_write(0, 64'h0, 0, 1'b1);
    drain("drain_single", 200);

    // simultaneous AW; master 1 W ready first but must wait for master 0
    do_reset();
    w_en = 2'b10;
    gen_write(0, 64'h0, 7, 1'b0);
    gen_write(1, 64'h4000_0000, 7, 1'b0);
    repeat (12) @(posedge clk);
    w_en = 2'b11;
    drain("drain_dual", 500);
    chk("dual_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("dual_first_m0", grant_log[0], 0);
      chk("dual_second_m1", grant_log[1], 1);
    end

    // owner FIFO fills: 5 AWs from master 1 with W held off
    do_reset();
    w_en = 2'b01;
    for (int k = 0; k < 5; k++) gen_write(1, {$urandom, $urandom}, 1, 1'b0);
    repeat (30) @(posedge clk);
    chk("m1_grants_when_full", grant_log.size(), OWN_DEPTH);
    w_en = 2'b11;
    drain("drain_full", 500);
    chk("m1_grants_total", grant_log.size(), 5);

    // random traffic with random backpressure
    do_reset();
    rdy_p = 60; aw_gap = 30; w_gap = 30;
    for (int k = 0; k < 30; k++) begin
      gen_write($urandom_range(1), {$urandom, $urandom}, $urandom_range(7), 1'b0);
      repeat ($urandom_range(4)) @(posedge clk);
    end
    drain("drain_random", 5000);
    rdy_p = 100; aw_gap = 0; w_gap = 0;

    // reset in the middle of an 8-beat burst, then a fresh write
    do_reset();
    gen_write(0, 64'h1000, 7, 1'b0);
    n = 0;
    while (mw_beats0 < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midburst_reached", mw_beats0 >= 3, 1'b1);
    do_reset();
    gen_write(0, 64'h2000, 3, 1'b0);
    drain("drain_after_reset", 300);

    // master 0 requests continuously against master 1
    do_reset();
    for (int k = 0; k < 4; k++) gen_write(0, 64'h100 * k, 0, 1'b0);
    gen_write(1, 64'h8000, 0, 1'b0);
    drain("drain_prio", 500);
    idx = -1;
    for (int k = 0; k < grant_log.size(); k++)
      if (idx < 0 && grant_log[k] == 1) idx = k;
`ifdef HBM_ARB_FIXED_PRIO_EN
    chk("m1_grant_position", idx, 4);
`else
    chk("m1_grant_position", idx, 1);
`endif

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
